// File: rtl/osd_trace_pkg.sv
// Shared types and constants for the multi-channel trace packetizer.
// The flit struct carries one 16-bit word plus its valid/last qualifiers.
package osd_trace_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [1:0] EVENT_TYPE      = 2'b10;
  localparam int         STATUS_FLAG_POS = 15;
  localparam int         OVF_FLAG_POS    = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOURCE,
    ST_TS,
    ST_STATUS,
    ST_EVENT
  } pkt_state_e;

  function automatic int flits_for(input int width);
    return (width + 15) >> 4;
  endfunction

endpackage

// File: rtl/osd_trace_rr_arb.sv
// Combinational round-robin pick among requesting channels.
// The search starts at ptr and wraps; the first requester found wins.
module osd_trace_rr_arb
  import osd_trace_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [1:0]        grant,
  output logic              any_req
);

  // Walk offsets from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    grant = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((c == ((int'(ptr) + i) % NUM_CH)) && req[c]) grant = 2'(c);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/osd_trace_packetization_mc.sv
// Multi-channel trace packetizer: picks one channel per packet round-robin and
// serializes dest, source, optional timestamp, then event or status flits.
module osd_trace_packetization_mc
  import osd_trace_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          NUM_CH   = 2,
  parameter logic [15:0] DEST_ID  = 16'h0,
  parameter int          TS_WIDTH = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [9:0]                            id,
  input  logic [((TS_WIDTH > 0) ? TS_WIDTH : 1)-1:0] timestamp,
  input  logic [NUM_CH*WIDTH-1:0]               trace_data,
  input  logic [NUM_CH-1:0]                     trace_overflow,
  input  logic [NUM_CH-1:0]                     trace_valid,
  output logic [NUM_CH-1:0]                     trace_ready,
  output dii_flit                               debug_out,
  input  logic                                  debug_out_ready
);

  localparam int NUM_FLITS = flits_for(WIDTH);
  localparam int EVW       = NUM_FLITS * 16;
  localparam int TS_FLITS  = flits_for(TS_WIDTH);
  localparam int TSF       = (TS_FLITS > 0) ? TS_FLITS : 1;
  localparam int TSP       = TSF * 16;

  pkt_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d, ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [TSP-1:0] ts_q, ts_d;

  logic [1:0]       arb_grant;
  logic             any_req;
  logic [WIDTH-1:0] cur_data;
  logic             cur_ovf;
  logic [EVW-1:0]   ev_pad;
  logic [15:0]      ev_flit, ts_flit;
  logic [1:0]       next_ptr;

  osd_trace_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req     (trace_valid),
    .ptr     (ptr_q),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  // Channel and flit selection by the registered grant / flit counter.
  always_comb begin
    cur_data = trace_data[WIDTH-1:0];
    cur_ovf  = trace_overflow[0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == 2'(c)) begin
        cur_data = trace_data[c*WIDTH +: WIDTH];
        cur_ovf  = trace_overflow[c];
      end
    end
    ev_pad  = EVW'(cur_data);
    ev_flit = 16'h0;
    for (int i = 0; i < NUM_FLITS; i++) begin
      if (cnt_q == 16'(i)) ev_flit = ev_pad[i*16 +: 16];
    end
    ts_flit = 16'h0;
    for (int i = 0; i < TSF; i++) begin
      if (cnt_q == 16'(i)) ts_flit = ts_q[i*16 +: 16];
    end
    next_ptr = (grant_q == 2'(NUM_CH - 1)) ? 2'd0 : grant_q + 2'd1;
  end

  // Handshake: a flit moves when debug_out.valid && debug_out_ready; once valid
  // rises the flit holds until it moves. trace_ready pulses only on the final move.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    ts_d        = ts_q;
    debug_out   = '0;
    trace_ready = '0;
    case (state_q)
      ST_IDLE: begin
        debug_out.valid = any_req;
        debug_out.data  = DEST_ID;
        if (any_req && debug_out_ready) begin
          grant_d = arb_grant;
          ts_d    = (TS_WIDTH > 0) ? TSP'(timestamp) : '0;
          state_d = ST_SOURCE;
        end
      end
      ST_SOURCE: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {EVENT_TYPE, ((NUM_CH == 1) ? 2'b00 : grant_q), cur_ovf, 1'b0, id};
        if (debug_out_ready) begin
          cnt_d = 16'd0;
          ovf_d = cur_ovf;
          if (TS_WIDTH > 0) state_d = ST_TS;
          else              state_d = cur_ovf ? ST_STATUS : ST_EVENT;
        end
      end
      ST_TS: begin
        debug_out.valid = 1'b1;
        debug_out.data  = ts_flit;
        if (debug_out_ready) begin
          if (cnt_q == 16'(TSF - 1)) begin
            cnt_d   = 16'd0;
            state_d = ovf_q ? ST_STATUS : ST_EVENT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_STATUS: begin
        debug_out.valid = 1'b1;
        debug_out.last  = 1'b1;
        debug_out.data  = {1'b1, 5'h0, ev_pad[9:0]};
        if (debug_out_ready) begin
          for (int c = 0; c < NUM_CH; c++) trace_ready[c] = (grant_q == 2'(c));
          ptr_d   = next_ptr;
          state_d = ST_IDLE;
        end
      end
      ST_EVENT: begin
        debug_out.valid = 1'b1;
        debug_out.last  = (cnt_q == 16'(NUM_FLITS - 1));
        debug_out.data  = ev_flit;
        if (debug_out_ready) begin
          if (cnt_q == 16'(NUM_FLITS - 1)) begin
            for (int c = 0; c < NUM_CH; c++) trace_ready[c] = (grant_q == 2'(c));
            ptr_d   = next_ptr;
            cnt_d   = 16'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      debug_out   = '0;
      trace_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 16'd0;
      ovf_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ts_q    <= ts_d;
    end
  end

endmodule
